spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, giving the word width in bits (legal values 4..32).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ss_n  input  1  SPI slave select, active-low, asynchronous to clk.
REQ-005 SHALL have port sclk  input  1  SPI clock from the master, CPOL=0, asynchronous to clk.
REQ-006 SHALL have port mosi  input  1  serial data from the master, MSB first.
REQ-007 SHALL have port miso  output  1  serial data to the master, MSB first.
REQ-008 SHALL have port tx_data  input  DWIDTH  next word to return to the master.
REQ-009 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-010 SHALL have port tx_ready  output  1  the transmit holding buffer is empty.
REQ-011 SHALL have port rx_data  output  DWIDTH  last complete word received.
REQ-012 SHALL have port rx_valid  output  1  rx_data holds an unacknowledged word.
REQ-013 SHALL have port rx_ack  input  1  single-cycle acknowledge that clears rx_valid.
REQ-014 SHALL have port rx_overrun  output  1  sticky overrun flag (see REQ-031).

Function
REQ-015 SHALL pass ss_n, sclk and mosi through 2-flop synchronizers and detect sclk edges from the last two synchronized samples; the master's SCLK high and low times are each at least 4 clk periods.
REQ-016 SHALL implement FSM IDLE/SHIFT: IDLE->SHIFT when synchronized ss_n is low; SHIFT->IDLE when it is high; SHIFT->SHIFT otherwise.
REQ-017 SHALL, on IDLE->SHIFT and on each word completion while ss_n stays low, load the shift register from the holding buffer and clear tx_full if tx_full=1; otherwise load all zeros.
REQ-018 SHALL drive miso = shift register MSB in SHIFT and 0 in IDLE.
REQ-019 SHALL, in SHIFT, capture synchronized mosi into a sample flop on each synchronized sclk rising edge and increment the bit counter.
REQ-020 SHALL, on each synchronized sclk falling edge in SHIFT, shift the register left by one and insert the sample flop at the LSB.
REQ-021 SHALL complete a word on the falling edge that follows the DWIDTH-th rising edge, then copy the shift register to rx_data and set rx_valid on the next clk.
REQ-022 SHALL reset the bit counter to 0 at word completion and support back-to-back words with ss_n held low.
REQ-023 SHALL accept tx_data into the holding buffer when tx_valid & tx_ready, set tx_full, and drive tx_ready = ~tx_full.
REQ-024 SHALL give the shift-register load priority when a load and a tx accept fall on the same clk: the old buffer is consumed and the new word is written, so tx_full stays 1.
REQ-025 SHALL clear rx_valid on rx_ack; if a new word completes in the same clk, rx_valid stays 1 and rx_data takes the new word.
REQ-026 SHALL, when ss_n deasserts mid-word, discard the partial word, reset the bit counter, leave rx_valid and rx_data unchanged, and leave any unconsumed holding buffer intact.
REQ-027 SHALL ignore sclk edges while synchronized ss_n is high.

Reset
REQ-028 SHALL, while rst is high, force the FSM to IDLE and set: bit counter 0, shift register 0, holding buffer 0, tx_full 0 (tx_ready 1), rx_data 0, rx_valid 0, rx_overrun 0, miso 0, synchronizers 1 for ss_n and 0 for sclk and mosi.
REQ-029 SHALL abort any frame in progress when reset asserts mid-word, and SHALL see a new frame only after ss_n is seen high and then low again.

Configuration
REQ-030 SHALL use preprocessor macro SPI_SLAVE_OVERRUN_EN to compile the overrun detector in or out.
REQ-031 SHALL, with SPI_SLAVE_OVERRUN_EN defined, set rx_overrun when a word completes while rx_valid=1 and rx_ack=0, and clear it only on rx_ack or rst; rx_data is overwritten in either case.
REQ-032 SHALL, with SPI_SLAVE_OVERRUN_EN undefined, tie rx_overrun to 0; the port is still present.

Verification
REQ-033 SHALL verify: tx_data=0xA5 loaded, one 8-bit frame with MOSI 0x3C -> master receives 0xA5 on miso; rx_data=0x3C and rx_valid=1.
REQ-034 SHALL verify: two back-to-back words with ss_n held low, MOSI 0x12 then 0x34 and tx 0x81 then 0x7E -> two rx_valid events (0x12, 0x34) with rx_ack between them; master receives 0x81 then 0x7E.
REQ-035 SHALL verify: ss_n deasserted after 5 bits -> no rx_valid and bit counter 0; the next full frame with 0xC3 gives rx_data=0xC3.
REQ-036 SHALL verify: a frame with tx buffer empty -> miso 0x00 throughout and tx_ready stays 1.
REQ-037 SHALL verify: two words received with no rx_ack -> rx_data=second word; rx_overrun=1 with the macro and 0 without; rx_ack clears both flags.
REQ-038 SHALL verify: rst pulsed mid-word -> all outputs at reset values; the frame after an ss_n high-to-low cycle with 0x5A gives rx_data=0x5A.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave -- SPI mode-0 (CPOL=0, CPHA=0) slave sampled entirely in the clk domain.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   ss_n, sclk, mosi  SPI pins from the master (asynchronous, synchronized here)
//   miso              serial data to the master, MSB first, 0 while not selected
//   tx_data/tx_valid  word offered for the next transfer; tx_ready = holding buffer empty
//   rx_data/rx_valid  last complete word received; rx_ack clears rx_valid
//   rx_overrun        sticky: a word landed while the previous one was unacknowledged
//
// Build option
//   SPI_SLAVE_OVERRUN_EN  when defined, the overrun detector is compiled in;
//                         otherwise rx_overrun is tied to 0.
//
// The master's SCLK high/low times must each be at least 4 clk periods.
module spi_slave #(
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss_n,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   input  logic [DWIDTH-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DWIDTH-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              rx_overrun
);

   localparam int CW = $clog2(DWIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nxt;

   // synchronizers
   logic ss_s1, ss_s2;
   logic sclk_s1, sclk_s2, sclk_d;
   logic mosi_s1, mosi_s2;

   // After reset the slave must see ss_n high before it accepts a frame, so a
   // frame that was cut by reset with ss_n still low is not resumed. The
   // ss_n synchronizer resets to 1, so its output is trusted only once it has
   // been refilled from the pin (prime).
   logic [1:0] prime;
   logic       armed;

   logic [CW-1:0]     bit_cnt;
   logic [DWIDTH-1:0] shreg;
   logic              sample;
   logic              done_q;
   logic [DWIDTH-1:0] tx_buf;
   logic              tx_full;

   logic rise, fall, act, comp, load, tx_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_s1   <= 1'b1;
         ss_s2   <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_d  <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         prime   <= 2'b00;
         armed   <= 1'b0;
      end else begin
         ss_s1   <= ss_n;
         ss_s2   <= ss_s1;
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
         prime   <= {prime[0], 1'b1};
         if (prime[1] && ss_s2)
            armed <= 1'b1;
      end
   end

   assign rise   = sclk_s2 & ~sclk_d;
   assign fall   = ~sclk_s2 & sclk_d;
   assign act    = (state == SHIFT) && !ss_s2;
   assign comp   = act && fall && (bit_cnt == CW'(DWIDTH));
   assign tx_acc = tx_valid & ~tx_full;

   // FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // done_q marks the clk after a word completed: the completed word is
   // copied out and the next one is loaded in the same clk.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (armed && !ss_s2) begin
               state_nxt = SHIFT;
               load      = 1'b1;
            end
         end
         SHIFT: begin
            if (ss_s2)
               state_nxt = IDLE;
            else if (done_q)
               load = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // shift datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;
         shreg   <= '0;
         sample  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= comp;

         if (!act || comp)
            bit_cnt <= '0;
         else if (rise)
            bit_cnt <= bit_cnt + 1'b1;

         if (act && rise)
            sample <= mosi_s2;

         if (load)
            shreg <= tx_full ? tx_buf : '0;
         else if (act && fall)
            shreg <= {shreg[DWIDTH-2:0], sample};
      end
   end

   // transmit holding buffer; a load consumes the old word, an accept in the
   // same clk still leaves the buffer full with the new word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_buf  <= '0;
         tx_full <= 1'b0;
      end else begin
         if (tx_acc) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
         end else if (load && tx_full) begin
            tx_full <= 1'b0;
         end
      end
   end

   assign tx_ready = ~tx_full;
   assign miso     = (state == SHIFT) ? shreg[DWIDTH-1] : 1'b0;

   // receive side; a new word wins over an acknowledge in the same clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         if (done_q) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rx_overrun <= 1'b0;
      else if (done_q && rx_valid && !rx_ack)
         rx_overrun <= 1'b1;
      else if (rx_ack)
         rx_overrun <= 1'b0;
   end
`else
   assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss_n = 1'b1;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       miso;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack = 1'b0;
   logic       rx_overrun;

   int total = 0;
   int bad   = 0;

`ifdef SPI_SLAVE_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   spi_slave #(.DWIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ss_n       (ss_n),
      .sclk       (sclk),
      .mosi       (mosi),
      .miso       (miso),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // SCLK half period of 8 clks; miso is taken just before each rising edge
   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = mo[i];
         wclk(8);
         mi[i] = miso;
         sclk = 1'b1;
         wclk(8);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
      ss_n = 1'b0;
      wclk(8);
      xfer(mo, 8, mi);
      wclk(8);
      ss_n = 1'b1;
      wclk(8);
   endtask

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic ack();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   logic [7:0] mi;

   initial begin
      // reset state
      wclk(3);
      check("rst_miso", miso, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_overrun", rx_overrun, 0);
      rst = 1'b0;
      wclk(6);

      // single frame, tx 0xA5, mosi 0x3C
      push(8'hA5);
      check("a_tx_ready_full", tx_ready, 0);
      frame(8'h3C, mi);
      check("a_miso_word", mi, 8'hA5);
      check("a_rx_data", rx_data, 8'h3C);
      check("a_rx_valid", rx_valid, 1);
      check("a_tx_ready", tx_ready, 1);
      ack();
      check("a_ack_clears", rx_valid, 0);

      // back-to-back words with ss_n held low
      push(8'h81);
      ss_n = 1'b0;
      wclk(8);
      push(8'h7E);
      check("b_tx_ready_full", tx_ready, 0);
      xfer(8'h12, 8, mi);
      check("b_miso_w0", mi, 8'h81);
      wclk(8);
      check("b_rx_data0", rx_data, 8'h12);
      check("b_rx_valid0", rx_valid, 1);
      check("b_tx_consumed", tx_ready, 1);
      ack();
      check("b_ack0", rx_valid, 0);
      xfer(8'h34, 8, mi);
      check("b_miso_w1", mi, 8'h7E);
      wclk(8);
      check("b_rx_data1", rx_data, 8'h34);
      check("b_rx_valid1", rx_valid, 1);
      ss_n = 1'b1;
      wclk(8);
      ack();

      // ss_n dropped after 5 bits, then a full frame 0xC3
      ss_n = 1'b0;
      wclk(8);
      xfer(8'hFF, 5, mi);
      wclk(4);
      ss_n = 1'b1;
      wclk(16);
      check("c_partial_no_valid", rx_valid, 0);
      check("c_partial_rx_data", rx_data, 8'h34);
      frame(8'hC3, mi);
      check("c_rx_data", rx_data, 8'hC3);
      check("c_rx_valid", rx_valid, 1);
      ack();

      // empty tx buffer returns zeros
      frame(8'h96, mi);
      check("d_miso_zero", mi, 8'h00);
      check("d_tx_ready", tx_ready, 1);
      check("d_rx_data", rx_data, 8'h96);
      ack();

      // two words without acknowledge
      frame(8'h11, mi);
      check("e_overrun_first", rx_overrun, 0);
      frame(8'h22, mi);
      check("e_rx_data", rx_data, 8'h22);
      check("e_rx_valid", rx_valid, 1);
      check("e_overrun", rx_overrun, OVR_EXP);
      ack();
      check("e_ack_valid", rx_valid, 0);
      check("e_ack_overrun", rx_overrun, 0);

      // reset in the middle of a word
      frame(8'h77, mi);
      push(8'h99);
      ss_n = 1'b0;
      wclk(8);
      xfer(8'h0F, 3, mi);
      @(negedge clk);
      rst = 1'b1;
      wclk(3);
      check("f_rst_miso", miso, 0);
      check("f_rst_tx_ready", tx_ready, 1);
      check("f_rst_rx_valid", rx_valid, 0);
      check("f_rst_rx_data", rx_data, 8'h00);
      check("f_rst_overrun", rx_overrun, 0);
      rst = 1'b0;
      // ss_n still low: no frame until it has been seen high
      wclk(8);
      xfer(8'hEE, 8, mi);
      wclk(8);
      check("f_no_frame", rx_valid, 0);
      ss_n = 1'b1;
      wclk(8);
      frame(8'h5A, mi);
      check("f_rx_data", rx_data, 8'h5A);
      check("f_rx_valid", rx_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
